alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Sequences the combinational 8/16-bit ALU: accepts one operation request (op, high/low operand selects,
//  repeat count), drives the one-hot PA_* operation and PA_Select_* lines, captures result and flags
//  each pass, and repeats for block-style iterations (e.g. CPIR/CPDR-style compare loops) with optional
//  early stop on a zero result. Sits between microcode decode and the ALU; sole driver of its controls.
// PARAMETERS
//  N_OPS      19  number of ALU operations (PA_NOP..PA_RRD), one-hot width of aluOp
//  N_SEL_HI   20  number of high-operand selects (A..0x1), one-hot width
//  N_SEL_LO   44  number of low-operand selects (A..0x80), one-hot width
// PORTS
//  clk            in   1         system clock, rising edge
//  notReset       in   1         asynchronous, active-low reset
//  reqValid       in   1         request offered
//  reqReady       out  1         request accepted when reqValid & reqReady
//  reqOp          in   5         operation code, 0=NOP .. 18=RRD (package enum)
//  reqSelHi       in   5         high-operand select code, 0..N_SEL_HI-1
//  reqSelLo       in   6         low-operand select code, 0..N_SEL_LO-1
//  reqCount       in   8         passes to run; 0 means 256
//  reqStopOnZero  in   1         end early when isResult0 after a pass
//  abort          in   1         synchronous cancel of the running sequence
//  notResult      in   16        ALU result (active-low)
//  aluFlags       in   8         {isResult0,is8bitOverflow,is16bitOverflow,notIs8bitEvenParity,CY16,notCY8,notCY4,DAA_Flag_H}
//  aluOp          out  N_OPS     one-hot PA_* lines, active-high
//  aluSelHi       out  N_SEL_HI  PA_Select_*_high lines, per-bit polarity from SEL_HI_ACTIVE_LOW
//  aluSelLo       out  N_SEL_LO  PA_Select_*_low lines, per-bit polarity from SEL_LO_ACTIVE_LOW
//  wbValid        out  1         one-cycle pulse: resultQ/flagsQ hold this pass's capture
//  resultQ        out  16        captured result, true polarity (inverted notResult)
//  flagsQ         out  8         captured aluFlags
//  passesLeft     out  9         remaining passes incl. current (1..256), 0 when idle
//  busy           out  1         high outside IDLE
//  done           out  1         one-cycle pulse when sequence ends (normal or early stop)
// BEHAVIOUR
//  Reset (async, notReset=0): state IDLE; reqReady=1, aluOp=only NOP bit set, all selects inactive
//   (active-high bits 0, active-low bits 1), wbValid=0, done=0, busy=0, resultQ=0, flagsQ=0, passesLeft=0.
//  States: IDLE -> DRIVE -> CAPTURE -> (DRIVE | DONE) -> IDLE.
//  IDLE: reqReady=1; on reqValid latch op/sels/stopOnZero, passesLeft = (reqCount==0)?256:reqCount; -> DRIVE.
//  DRIVE (1 cycle, ALU settle): aluOp/aluSel* driven from latched codes; reqReady=0.
//  CAPTURE (1 cycle): controls held; at edge leaving CAPTURE register resultQ=~notResult, flagsQ=aluFlags,
//   wbValid=1 for the following cycle; passesLeft decrements.
//  Next after CAPTURE: DONE if passesLeft was 1, or reqStopOnZero & isResult0; else DRIVE.
//  DONE (1 cycle): done=1, controls idle (NOP, selects inactive); -> IDLE. Latency single pass: accept
//   edge +3 cycles to done; N passes: 2N+1 cycles; min request spacing 2N+2.
//  Between passes controls stay driven (no NOP gap); a pass boundary is DRIVE after CAPTURE.
//  abort=1 in DRIVE/CAPTURE/DONE: -> IDLE next edge, no wbValid, no done, resultQ/flagsQ keep last value.
//   abort in IDLE ignored; abort with reqValid in IDLE: request accepted.
//  Illegal codes (reqOp>18, reqSelHi>=N_SEL_HI, reqSelLo>=N_SEL_LO): request accepted, aluOp=NOP,
//   selects all inactive, passes run normally (captures whatever the ALU presents).
//  Exactly one aluOp bit high at all times; at most one select bit active per bus.
//  reset mid-sequence: immediate return to reset values, no done.
// STRUCTURE
//  Package alu_seq_pkg: op enum (NOP..RRD, 5 bit), select-code enums for high/low, SEL_HI_ACTIVE_LOW and
//   SEL_LO_ACTIVE_LOW polarity masks, flag bit index constants, state enum.
//  Sub-module alu_select_decoder: code + enable -> one-hot, XOR with polarity mask; instanced 3x (op, hi, lo).
// TESTING
//  ADD, selHi=A, selLo=B, count=1, notResult=16'hFFF0 -> aluOp ADD one-hot in DRIVE/CAPTURE, wbValid once,
//   resultQ=16'h000F, done at accept+3, reqReady low 3 cycles.
//  SUB, count=4, stopOnZero=1, isResult0 set on 3rd capture -> exactly 3 wbValid, done, passesLeft 0.
//  count=0 -> 256 passes, 256 wbValid pulses, done at accept+513 cycles.
//  abort asserted in 2nd CAPTURE of count=5 -> 1 wbValid only, no done, IDLE next cycle, reqReady=1.
//  reqOp=25, reqSelLo=50 -> aluOp=NOP, selects inactive per masks, done still pulses.
//  notReset low during DRIVE -> all outputs reset values same cycle; next request behaves normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: bus widths, operation and operand-select codes,
// per-bit select polarity masks, flag bit positions and FSM state constants.
package alu_seq_pkg;

  localparam int unsigned ALU_N_OPS    = 19;
  localparam int unsigned ALU_N_SEL_HI = 20;
  localparam int unsigned ALU_N_SEL_LO = 44;

  // Operation codes; the code is the bit position on the one-hot PA_* bus.
  typedef enum logic [4:0] {
    OpNop  = 5'd0,
    OpAdd  = 5'd1,
    OpAdc  = 5'd2,
    OpSub  = 5'd3,
    OpSbc  = 5'd4,
    OpAnd  = 5'd5,
    OpXor  = 5'd6,
    OpOr   = 5'd7,
    OpCp   = 5'd8,
    OpInc  = 5'd9,
    OpDec  = 5'd10,
    OpRlc  = 5'd11,
    OpRrc  = 5'd12,
    OpRl   = 5'd13,
    OpRr   = 5'd14,
    OpDaa  = 5'd15,
    OpCpl  = 5'd16,
    OpRld  = 5'd17,
    OpRrd  = 5'd18
  } alu_op_e;

  // High-operand select codes (bit position on the PA_Select_*_high bus).
  typedef enum logic [4:0] {
    SelHiA, SelHiF, SelHiB, SelHiC, SelHiD, SelHiE, SelHiH, SelHiL,
    SelHiIxh, SelHiIxl, SelHiIyh, SelHiIyl, SelHiSph, SelHiSpl, SelHiPch, SelHiPcl,
    SelHiTmp, SelHiI, SelHiR, SelHiConst01
  } sel_hi_e;

  // Low-operand select codes (bit position on the PA_Select_*_low bus).
  typedef enum logic [5:0] {
    SelLoA, SelLoF, SelLoB, SelLoC, SelLoD, SelLoE, SelLoH, SelLoL,
    SelLoIxh, SelLoIxl, SelLoIyh, SelLoIyl, SelLoSph, SelLoSpl, SelLoPch, SelLoPcl,
    SelLoTmp, SelLoI, SelLoR, SelLoData, SelLoAdrLo, SelLoAdrHi, SelLoImm,
    SelLoConst00, SelLoConstFF, SelLoConstFE, SelLoConstFD, SelLoConstFB, SelLoConstF7,
    SelLoConstEF, SelLoConstDF, SelLoConstBF, SelLoConst7F, SelLoConst06, SelLoConst60,
    SelLoConst66, SelLoConst01, SelLoConst02, SelLoConst04, SelLoConst08, SelLoConst10,
    SelLoConst20, SelLoConst40, SelLoConst80
  } sel_lo_e;

  // A set bit marks a select line that the ALU treats as active-low.
  localparam logic [ALU_N_SEL_HI-1:0] SEL_HI_ACTIVE_LOW = 20'h3_0F00;
  localparam logic [ALU_N_SEL_LO-1:0] SEL_LO_ACTIVE_LOW = 44'h00F_0000_00F4;

  // Bit positions within aluFlags.
  localparam int unsigned FLAG_RESULT0  = 7;
  localparam int unsigned FLAG_OVF8     = 6;
  localparam int unsigned FLAG_OVF16    = 5;
  localparam int unsigned FLAG_NPARITY8 = 4;
  localparam int unsigned FLAG_CY16     = 3;
  localparam int unsigned FLAG_NCY8     = 2;
  localparam int unsigned FLAG_NCY4     = 1;
  localparam int unsigned FLAG_DAA_H    = 0;

  typedef logic [1:0] seq_state_t;
  localparam seq_state_t StIdle    = 2'd0;
  localparam seq_state_t StDrive   = 2'd1;
  localparam seq_state_t StCapture = 2'd2;
  localparam seq_state_t StDone    = 2'd3;

  // A repeat count of zero encodes the maximum of 256 passes.
  function automatic logic [8:0] passes_from_count(input logic [7:0] count);
    return (count == 8'd0) ? 9'd256 : {1'b0, count};
  endfunction

endpackage

// File: rtl/alu_select_decoder.sv
// Code-to-one-hot decoder with per-bit output polarity.
//  code_i  binary code; codes >= Width decode to no active line
//  en_i    when low no line is active
//  sel_o   one-hot (active-high) XOR ActiveLowMask, so inactive lines sit at their idle level
module alu_select_decoder #(
  parameter int unsigned     Width         = 8,
  parameter int unsigned     CodeW         = 3,
  parameter logic [Width-1:0] ActiveLowMask = '0
) (
  input  logic [CodeW-1:0] code_i,
  input  logic             en_i,
  output logic [Width-1:0] sel_o
);

  logic [Width-1:0] onehot;

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      onehot[i] = en_i && (code_i == CodeW'(i));
    end
  end

  assign sel_o = onehot ^ ActiveLowMask;

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer for the combinational 8/16-bit ALU. Accepts one request (op, operand selects,
// repeat count, stop-on-zero), drives the one-hot operation and select buses for each pass,
// captures the result and flags at the end of every pass and optionally ends early on a zero
// result.
//  clk, notReset                clock, asynchronous active-low reset
//  reqValid/reqReady            request handshake; reqOp/reqSelHi/reqSelLo/reqCount/reqStopOnZero
//  abort                        synchronous cancel of a running sequence
//  notResult, aluFlags          ALU result (active-low) and flags
//  aluOp, aluSelHi, aluSelLo    ALU control buses
//  wbValid, resultQ, flagsQ     per-pass capture and its one-cycle valid strobe
//  passesLeft, busy, done       progress and completion status
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N_OPS    = ALU_N_OPS,
  parameter int unsigned N_SEL_HI = ALU_N_SEL_HI,
  parameter int unsigned N_SEL_LO = ALU_N_SEL_LO
) (
  input  logic                clk,
  input  logic                notReset,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic [4:0]          reqOp,
  input  logic [4:0]          reqSelHi,
  input  logic [5:0]          reqSelLo,
  input  logic [7:0]          reqCount,
  input  logic                reqStopOnZero,
  input  logic                abort,
  input  logic [15:0]         notResult,
  input  logic [7:0]          aluFlags,
  output logic [N_OPS-1:0]    aluOp,
  output logic [N_SEL_HI-1:0] aluSelHi,
  output logic [N_SEL_LO-1:0] aluSelLo,
  output logic                wbValid,
  output logic [15:0]         resultQ,
  output logic [7:0]          flagsQ,
  output logic [8:0]          passesLeft,
  output logic                busy,
  output logic                done
);

  seq_state_t  state_q, state_d;
  logic [8:0]  passes_q, passes_d;
  logic [4:0]  op_q;
  logic [4:0]  sel_hi_q;
  logic [5:0]  sel_lo_q;
  logic        stop_zero_q;
  logic [15:0] result_q;
  logic [7:0]  flags_q;
  logic        wb_valid_q;

  logic        accept;
  logic        capture_fire;
  logic        last_pass;
  logic        drive_en;
  logic [4:0]  op_code;

  assign accept       = (state_q == StIdle) && reqValid;
  assign capture_fire = (state_q == StCapture) && !abort;
  assign last_pass    = (passes_q == 9'd1) || (stop_zero_q && aluFlags[FLAG_RESULT0]);
  assign drive_en     = (state_q == StDrive) || (state_q == StCapture);

  always_comb begin
    state_d  = state_q;
    passes_d = passes_q;
    unique case (state_q)
      StIdle: begin
        if (reqValid) begin
          state_d  = StDrive;
          passes_d = passes_from_count(reqCount);
        end
      end
      StDrive: begin
        if (abort) begin
          state_d  = StIdle;
          passes_d = 9'd0;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (abort) begin
          state_d  = StIdle;
          passes_d = 9'd0;
        end else if (last_pass) begin
          // An early stop also leaves nothing outstanding.
          state_d  = StDone;
          passes_d = 9'd0;
        end else begin
          state_d  = StDrive;
          passes_d = passes_q - 9'd1;
        end
      end
      StDone: begin
        state_d  = StIdle;
        passes_d = 9'd0;
      end
      default: begin
        state_d  = StIdle;
        passes_d = 9'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q     <= StIdle;
      passes_q    <= 9'd0;
      op_q        <= 5'd0;
      sel_hi_q    <= 5'd0;
      sel_lo_q    <= 6'd0;
      stop_zero_q <= 1'b0;
      result_q    <= 16'd0;
      flags_q     <= 8'd0;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      passes_q   <= passes_d;
      wb_valid_q <= capture_fire;
      if (accept) begin
        op_q        <= reqOp;
        sel_hi_q    <= reqSelHi;
        sel_lo_q    <= reqSelLo;
        stop_zero_q <= reqStopOnZero;
      end
      if (capture_fire) begin
        result_q <= ~notResult;
        flags_q  <= aluFlags;
      end
    end
  end

  // Illegal op codes and idle phases fall back to NOP so exactly one op line is always high.
  always_comb begin
    op_code = OpNop;
    if (drive_en && (op_q < 5'(N_OPS))) begin
      op_code = op_q;
    end
  end

  alu_select_decoder #(
    .Width        (N_OPS),
    .CodeW        (5),
    .ActiveLowMask('0)
  ) u_op_dec (
    .code_i(op_code),
    .en_i  (1'b1),
    .sel_o (aluOp)
  );

  alu_select_decoder #(
    .Width        (N_SEL_HI),
    .CodeW        (5),
    .ActiveLowMask(SEL_HI_ACTIVE_LOW)
  ) u_hi_dec (
    .code_i(sel_hi_q),
    .en_i  (drive_en),
    .sel_o (aluSelHi)
  );

  alu_select_decoder #(
    .Width        (N_SEL_LO),
    .CodeW        (6),
    .ActiveLowMask(SEL_LO_ACTIVE_LOW)
  ) u_lo_dec (
    .code_i(sel_lo_q),
    .en_i  (drive_en),
    .sel_o (aluSelLo)
  );

  assign reqReady   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  // An abort in the done cycle cancels the completion pulse as well.
  assign done       = (state_q == StDone) && !abort;
  assign wbValid    = wb_valid_q;
  assign resultQ    = result_q;
  assign flagsQ     = flags_q;
  assign passesLeft = passes_q;

endmodule
